return_address_stack: RTL
=========================

Name: return_address_stack

Overview:
- Hardware return-address stack (RAS) that supplies the `stack` operand to the next-address selector.
- On a call it pushes the return address, which is the already-incremented PC.
- On a return the selector picks STACK (pc_select = 3'b000), consumes `top`, and this block pops.
- Sits in EX beside the next-address mux, driven by the control unit's call/return decode.

Parameters:
- WIDTH, 32, address width in bits.
- DEPTH, 8, number of entries; must be a power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), stack-pointer width; derived, do not override.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  call retiring this cycle; write `push_data`.
- pop  in  1  return retiring this cycle; discard the top entry.
- flush  in  1  pipeline flush; empty the stack. Same effect as reset, but status flags are preserved.
- push_data  in  WIDTH  return address to store (pc_1 of the call).
- top  out  WIDTH  current top-of-stack entry; combinational from state; 0 when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  PTR_W+1  number of valid entries, 0..DEPTH.
- overflow  out  1  sticky: a push was made while full.
- underflow  out  1  sticky: a pop was made while empty.

Behaviour:
- Reset, or flush with reset=0:
  - count <= 0; write pointer sp <= 0; entry memory is not cleared.
  - Resulting outputs: top=0, empty=1, full=0.
- Flags:
  - Reset clears overflow and underflow.
  - Flush does not clear them.
  - reset has priority over flush; flush has priority over push and pop.
- Storage:
  - Circular buffer mem[0..DEPTH-1].
  - sp indexes the next free slot; the top entry is mem[sp-1] mod DEPTH.
- Output timing:
  - top = mem[sp-1] when count>0, else 0.
  - Updates take effect the cycle after the edge that performs the push or pop; no same-cycle bypass of push_data to top.
- Push only (push=1, pop=0):
  - mem[sp] <= push_data; sp <= sp+1 (wraps modulo DEPTH).
  - Not full: count <= count+1.
  - Full: the oldest entry is silently overwritten; count stays DEPTH; overflow <= 1.
- Pop only (push=0, pop=1):
  - Not empty: sp <= sp-1 (wraps); count <= count-1.
  - Empty: no state change except underflow <= 1; top stays 0.
- Push and pop in the same cycle (return immediately followed by a call):
  - Not empty: mem[sp-1] <= push_data; sp and count unchanged, i.e. the top is replaced; no flags set, even when full.
  - Empty: treated as push only; underflow <= 1.
- Neither push nor pop: hold.
- Sticky flags stay set until reset.
- Wrap-around: after more than DEPTH pushes with no pops, a sequence of DEPTH pops returns the last DEPTH pushed values in LIFO order. The next pop then sets underflow.
- No X propagation: top is forced to 0 when empty, so the never-reset memory never drives the output while invalid.

Decomposition:
- Shared package (e.g. core_defs):
  - pc_select encodings STACK=3'b000, JR=3'b001, NPC=3'b010, JUMP=3'b011, BRANCH=3'b100, HALT=3'b101.
  - RAS_DEPTH default.
  - The package is used by both this block and the next-address selector so the encodings cannot diverge.
- Sub-module: ras_regfile, a DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port. The parent holds sp, count, flags and the priority logic. Otherwise a single module.

Test Plan:
- Reset behaviour: assert reset for 2 cycles after random pushes -> top=0, empty=1, count=0, overflow=0, underflow=0.
- Basic LIFO: push 0x00000104, 0x00000208, 0x0000030C on 3 cycles, then pop 3 times.
  - top reads 0x30C, then 0x208, then 0x104, then 0.
  - count steps 3,2,1,0; empty=1 at the end.
- Overflow wrap (DEPTH=8): push 0x10..0x90 step 0x10 (9 values).
  - full=1, count=8, overflow=1.
  - 8 pops yield 0x90 down to 0x20.
  - A 9th pop sets underflow=1 and leaves top=0.
- Simultaneous push and pop:
  - Stack [0x40,0x50], push=pop=1 with push_data=0x60 -> count=2, top=0x60; next pop -> top=0x40.
  - On empty, push=pop=1 with push_data=0x70 -> count=1, top=0x70, underflow=1.
- Flush mid-operation: with count=5 and overflow=1, assert flush together with push -> next cycle count=0, top=0, overflow still 1, and the push is ignored.
- Underflow on empty pop: pop with count=0 -> count stays 0, underflow=1 and stays set across 10 idle cycles until reset.

Source files
------------

// File: rtl/return_address_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : return_address_stack_pkg
// Description : Definitions shared by the return-address stack and the
//               next-address selector. Both blocks take their pc_select
//               encodings from this one place, so the encodings always
//               match.
//               Contents:
//                 pc_select_e  next-address source select (3 bits)
//                 c_ras_depth  default return-address stack depth
// Revision    : 1.0  initial release
// ============================================================================
package return_address_stack_pkg;

    // Next-address source select. STACK takes the return-address stack top.
    typedef enum logic [2:0] {
        c_pc_stack  = 3'b000,
        c_pc_jr     = 3'b001,
        c_pc_npc    = 3'b010,
        c_pc_jump   = 3'b011,
        c_pc_branch = 3'b100,
        c_pc_halt   = 3'b101
    } pc_select_e;

    // Default number of return-address stack entries (power of two, >= 2).
    localparam int c_ras_depth = 8;

endpackage : return_address_stack_pkg
`default_nettype wire

// File: rtl/ras_regfile.sv
`default_nettype none
// ============================================================================
// Module      : ras_regfile
// Description : DEPTH x WIDTH register array for the return-address stack.
//               It has one synchronous write port and one asynchronous read
//               port. The storage has no reset. The parent block never
//               drives an unwritten entry to its output.
//               Ports:
//                 clk      clock; the write happens on the rising edge
//                 i_we     write enable
//                 i_waddr  write index
//                 i_wdata  write data
//                 i_raddr  read index
//                 o_rdata  read data (combinational)
// Revision    : 1.0  initial release
// ============================================================================
module ras_regfile #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : ras_regfile
`default_nettype wire

// File: rtl/return_address_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_address_stack
// Description : Circular return-address stack. A call pushes its incremented
//               PC. A return pops the entry that the next-address selector
//               consumed through `top`. When the stack is full, a push
//               overwrites the oldest entry.
//               Ports:
//                 clock      system clock, rising edge
//                 reset      synchronous active-high reset (clears flags)
//                 push       call retiring: store push_data
//                 pop        return retiring: discard top entry
//                 flush      empty the stack, keep sticky flags
//                 push_data  return address to store
//                 top        current top entry, 0 when empty
//                 empty      count == 0
//                 full       count == DEPTH
//                 count      valid entries, 0..DEPTH
//                 overflow   sticky: push while full
//                 underflow  sticky: pop while empty
// Revision    : 1.0  initial release
// ============================================================================
module return_address_stack
    import return_address_stack_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = c_ras_depth,   // power of two, >= 2
    parameter int PTR_W = $clog2(DEPTH)  // derived, do not override
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W:0] c_full_count = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_sp;        // next free slot
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic [PTR_W-1:0] w_top_idx;
    logic             w_we;
    logic [PTR_W-1:0] w_waddr;
    logic [WIDTH-1:0] w_rdata;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full_count);
    // The pointer width equals log2(DEPTH), so subtraction wraps modulo DEPTH.
    assign w_top_idx = r_sp - 1'b1;

    // Memory write port. A push writes the free slot at sp. A push and a pop
    // in the same cycle on a non-empty stack replace the current top entry.
    // Reset and flush block the write. The memory is never cleared.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_sp;
        if (!reset && !flush && push) begin
            w_we = 1'b1;
            if (pop && !w_empty) begin
                w_waddr = w_top_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_sp    <= '0;
            r_count <= '0;
        end else if (push && pop) begin
            // On a non-empty stack the top is replaced in place and no state
            // changes here. On an empty stack this acts as a plain push.
            if (w_empty) begin
                r_sp        <= r_sp + 1'b1;
                r_count     <= r_count + 1'b1;
                r_underflow <= 1'b1;
            end
        end else if (push) begin
            r_sp <= r_sp + 1'b1;
            if (w_full) begin
                r_overflow <= 1'b1;       // oldest entry silently lost
            end else begin
                r_count <= r_count + 1'b1;
            end
        end else if (pop) begin
            if (w_empty) begin
                r_underflow <= 1'b1;
            end else begin
                r_sp    <= r_sp - 1'b1;
                r_count <= r_count - 1'b1;
            end
        end
    end

    ras_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_regfile (
        .clk     (clock),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (push_data),
        .i_raddr (w_top_idx),
        .o_rdata (w_rdata)
    );

    // Forcing top to 0 when empty keeps the unreset memory off the output.
    assign top       = w_empty ? '0 : w_rdata;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule : return_address_stack
`default_nettype wire
